// File: rtl/common_pkg.sv
// Shared NoC defaults, lock-state encoding and credit counter sizing helper.
package common_pkg;

  localparam int DEFAULT_VC_W          = 2;
  localparam int DEFAULT_D_W           = 32;
  localparam int DEFAULT_A_W           = 8;
  localparam int DEFAULT_VC_FIFO_DEPTH = 4;

  typedef enum logic {
    LK_IDLE   = 1'b0,
    LK_LOCKED = 1'b1
  } lock_state_t;

  // Counter must hold DEPTH-1; never narrower than one bit.
  function automatic int credit_cnt_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/noc_if.sv
// Point-to-point NoC link: one flit plus one-hot VC target forward, per-VC credits back.
interface noc_if #(
  parameter int VC_W = common_pkg::DEFAULT_VC_W,
  parameter int A_W  = common_pkg::DEFAULT_A_W,
  parameter int D_W  = common_pkg::DEFAULT_D_W
);

  typedef struct packed {
    logic           last;
    logic [D_W-1:0] data;
  } payload_t;

  typedef struct packed {
    logic [A_W-1:0] addr;
  } routeinfo_t;

  typedef struct packed {
    routeinfo_t routeinfo;
    payload_t   payload;
  } packet_t;

  logic [VC_W-1:0] vc_target;
  packet_t         packet;
  logic [VC_W-1:0] vc_credit_gnt;

  modport transmitter (output vc_target, output packet, input vc_credit_gnt);
  modport receiver    (input vc_target, input packet, output vc_credit_gnt);

endinterface

// File: rtl/vc_link_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past i_ptr and wraps modulo N.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx
);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    cand  = '0;
    found = 1'b0;
    // k = N revisits i_ptr itself last, so the previous winner has lowest priority.
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(i_ptr) + k) % N);
      if (!found && i_req[cand]) begin
        found       = 1'b1;
        o_gnt[cand] = 1'b1;
        o_idx       = cand;
      end
    end
  end

endmodule

// File: rtl/vc_link_scheduler.sv
// Credit-based per-VC link transmitter: round-robin picks one flit per cycle, optional packet lock.
module vc_link_scheduler
  import common_pkg::*;
#(
  parameter int VC_W     = DEFAULT_VC_W,
  parameter int D_W      = DEFAULT_D_W,
  parameter int A_W      = DEFAULT_A_W,
  parameter int DEPTH    = DEFAULT_VC_FIFO_DEPTH,
  parameter int LOCK_PKT = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [VC_W-1:0]              i_v,
  input  logic [VC_W-1:0][A_W+D_W:0]   i_d,
  output logic [VC_W-1:0]              o_b,
  noc_if.transmitter                   to_rx
);

  localparam int FW    = A_W + D_W + 1;
  localparam int IDX_W = (VC_W > 1) ? $clog2(VC_W) : 1;
  localparam int CNT_W = credit_cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH - 1);

  logic [CNT_W-1:0] credit_cnt [VC_W];
  logic [VC_W-1:0]  credit_rtn;
  logic [VC_W-1:0]  elig;
  logic [VC_W-1:0]  gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             any_gnt;
  logic [FW-1:0]    flit_sel;
  logic             sel_last;
  logic [IDX_W-1:0] ptr_p0;

  lock_state_t      lock_state, lock_state_nxt;
  logic [IDX_W-1:0] lock_vc, lock_vc_nxt;
  logic             locked;

  logic [VC_W-1:0]  vc_target_p0;
  logic [FW-1:0]    flit_p0;

  assign credit_rtn = to_rx.vc_credit_gnt;
  assign locked     = (LOCK_PKT != 0) && (lock_state == LK_LOCKED);

  // Eligibility uses the registered count only, so a same-cycle return cannot rescue cnt == 0.
  always_comb begin
    elig = '0;
    for (int v = 0; v < VC_W; v++) begin
      elig[v] = i_v[v] && (credit_cnt[v] != '0) && (!locked || (lock_vc == IDX_W'(v)));
    end
  end

  rr_arbiter #(.N(VC_W)) u_arb (
    .i_req (elig),
    .i_ptr (ptr_p0),
    .o_gnt (gnt),
    .o_idx (gnt_idx)
  );

  assign any_gnt  = |gnt;
  assign flit_sel = i_d[gnt_idx];
  assign sel_last = flit_sel[FW-1];
  assign o_b      = ~gnt;

  // Credit counters: send and return on the same VC cancel; return at full saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < VC_W; v++) credit_cnt[v] <= CNT_MAX;
    end else begin
      for (int v = 0; v < VC_W; v++) begin
        if (gnt[v] && !credit_rtn[v]) begin
          credit_cnt[v] <= credit_cnt[v] - 1'b1;
        end else if (!gnt[v] && credit_rtn[v] && (credit_cnt[v] != CNT_MAX)) begin
          credit_cnt[v] <= credit_cnt[v] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_p0 <= IDX_W'(VC_W - 1);
    end else if (any_gnt) begin
      ptr_p0 <= gnt_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_state <= LK_IDLE;
      lock_vc    <= '0;
    end else begin
      lock_state <= lock_state_nxt;
      lock_vc    <= lock_vc_nxt;
    end
  end

  always_comb begin
    lock_state_nxt = lock_state;
    lock_vc_nxt    = lock_vc;
    case (lock_state)
      LK_IDLE: begin
        if ((LOCK_PKT != 0) && any_gnt && !sel_last) begin
          lock_state_nxt = LK_LOCKED;
          lock_vc_nxt    = gnt_idx;
        end
      end
      LK_LOCKED: begin
        // Only lock_vc can be granted here, so any grant with last closes the packet.
        if (any_gnt && sel_last) lock_state_nxt = LK_IDLE;
      end
      default: lock_state_nxt = LK_IDLE;
    endcase
  end

  // Link stage: flit accepted this cycle is on the link next cycle; idle cycles drive zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vc_target_p0 <= '0;
      flit_p0      <= '0;
    end else begin
      vc_target_p0 <= gnt;
      flit_p0      <= any_gnt ? flit_sel : '0;
    end
  end

  assign to_rx.vc_target              = vc_target_p0;
  assign to_rx.packet.payload.last    = flit_p0[FW-1];
  assign to_rx.packet.routeinfo.addr  = flit_p0[FW-2:D_W];
  assign to_rx.packet.payload.data    = flit_p0[D_W-1:0];

`ifdef SIMULATION
  always @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(vc_target_p0)) else $error("vc_target not one-hot: %b", vc_target_p0);
      assert (!$isunknown(o_b)) else $error("o_b unknown: %b", o_b);
      for (int v = 0; v < VC_W; v++) begin
        assert (!(gnt[v] && (credit_cnt[v] == '0))) else $error("send on VC%0d with zero credit", v);
        assert (!(credit_rtn[v] && (credit_cnt[v] == CNT_MAX)))
          else $error("credit return on VC%0d at full count", v);
      end
    end
  end
`endif

endmodule

// File: tb/tb_vc_link_scheduler.sv
// Table-driven bench for vc_link_scheduler (4 VCs, DEPTH 4, packet lock enabled) with a link scoreboard.
module tb_vc_link_scheduler;

  localparam int VC_W  = 4;
  localparam int D_W   = 8;
  localparam int A_W   = 4;
  localparam int DEPTH = 4;
  localparam int FW    = A_W + D_W + 1;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [VC_W-1:0]           i_v;
  logic [VC_W-1:0][FW-1:0]   i_d;
  logic [VC_W-1:0]           o_b;

  noc_if #(.VC_W(VC_W), .A_W(A_W), .D_W(D_W)) rx ();

  vc_link_scheduler #(
    .VC_W(VC_W), .D_W(D_W), .A_W(A_W), .DEPTH(DEPTH), .LOCK_PKT(1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .i_v   (i_v),
    .i_d   (i_d),
    .o_b   (o_b),
    .to_rx (rx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_before;
    logic [3:0] iv;
    logic [3:0] last;
    logic [3:0] cgnt;
    logic [3:0] ob;
    logic [3:0] tgt;
  } vec_t;

  typedef struct packed {
    logic [VC_W-1:0] tgt;
    logic [FW-1:0]   pkt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   seed   = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [FW-1:0] link_pkt();
    return {rx.packet.payload.last, rx.packet.routeinfo.addr, rx.packet.payload.data};
  endfunction

  task automatic add(input logic r, input logic [3:0] iv, input logic [3:0] last,
                     input logic [3:0] cgnt, input logic [3:0] ob, input logic [3:0] tgt);
    vec_t t;
    t.rst_before = r; t.iv = iv; t.last = last; t.cgnt = cgnt; t.ob = ob; t.tgt = tgt;
    vecs.push_back(t);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    i_v = '0;
    rx.vc_credit_gnt = '0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // One cycle: drive at negedge, check o_b, expect the chosen flit on the link after the posedge.
  task automatic step(input logic [3:0] iv, input logic [3:0] last, input logic [3:0] cgnt,
                      input logic [3:0] exp_ob, input logic [3:0] exp_tgt, input string tag);
    exp_t e;
    @(negedge clk);
    i_v = iv;
    rx.vc_credit_gnt = cgnt;
    for (int v = 0; v < VC_W; v++) i_d[v] = {last[v], 4'(v), 8'(seed + v)};
    seed += 16;
    #1;
    chk({"o_b ", tag}, 32'(o_b), 32'(exp_ob));
    e.tgt = exp_tgt;
    e.pkt = '0;
    for (int v = 0; v < VC_W; v++) if (exp_tgt[v]) e.pkt = i_d[v];
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({"scoreboard empty ", tag}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({"vc_target ", tag}, 32'(rx.vc_target), 32'(e.tgt));
      chk({"packet ", tag}, 32'(link_pkt()), 32'(e.pkt));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    i_v = '0;
    i_d = '0;
    rx.vc_credit_gnt = '0;
    #12;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("reset vc_target", 32'(rx.vc_target), 32'd0);
    chk("reset packet", 32'(link_pkt()), 32'd0);
    chk("reset o_b idle", 32'(o_b), 32'hF);

    // Round-robin fairness from reset: VC0 first, then rotate.
    add(0, 4'b1111, 4'b1111, 4'b0000, 4'b1110, 4'b0001);
    add(0, 4'b1111, 4'b1111, 4'b0000, 4'b1101, 4'b0010);
    add(0, 4'b1111, 4'b1111, 4'b0000, 4'b1011, 4'b0100);
    add(0, 4'b1111, 4'b1111, 4'b0000, 4'b0111, 4'b1000);
    add(0, 4'b1111, 4'b1111, 4'b0000, 4'b1110, 4'b0001);
    // Credit exhaustion on VC0, then a single returned credit.
    add(1, 4'b0001, 4'b1111, 4'b0000, 4'b1110, 4'b0001);
    add(0, 4'b0001, 4'b1111, 4'b0000, 4'b1110, 4'b0001);
    add(0, 4'b0001, 4'b1111, 4'b0000, 4'b1110, 4'b0001);
    add(0, 4'b0001, 4'b1111, 4'b0000, 4'b1111, 4'b0000);
    add(0, 4'b0001, 4'b1111, 4'b0000, 4'b1111, 4'b0000);
    add(0, 4'b0001, 4'b1111, 4'b0001, 4'b1111, 4'b0000);
    add(0, 4'b0001, 4'b1111, 4'b0000, 4'b1110, 4'b0001);
    add(0, 4'b0001, 4'b1111, 4'b0000, 4'b1111, 4'b0000);
    // Simultaneous send and return on VC1 at count 1.
    add(1, 4'b0010, 4'b1111, 4'b0000, 4'b1101, 4'b0010);
    add(0, 4'b0010, 4'b1111, 4'b0000, 4'b1101, 4'b0010);
    add(0, 4'b0010, 4'b1111, 4'b0010, 4'b1101, 4'b0010);
    add(0, 4'b0010, 4'b1111, 4'b0000, 4'b1101, 4'b0010);
    add(0, 4'b0010, 4'b1111, 4'b0000, 4'b1111, 4'b0000);
    // Packet lock: VC2 three-flit packet holds off VC0.
    add(1, 4'b0100, 4'b0000, 4'b0000, 4'b1011, 4'b0100);
    add(0, 4'b0101, 4'b0000, 4'b0000, 4'b1011, 4'b0100);
    add(0, 4'b0101, 4'b0100, 4'b0000, 4'b1011, 4'b0100);
    add(0, 4'b0101, 4'b0101, 4'b0000, 4'b1110, 4'b0001);
    // Lock stall: VC2 out of credit mid-packet.
    add(1, 4'b0100, 4'b0000, 4'b0000, 4'b1011, 4'b0100);
    add(0, 4'b0101, 4'b0000, 4'b0000, 4'b1011, 4'b0100);
    add(0, 4'b0101, 4'b0000, 4'b0000, 4'b1011, 4'b0100);
    add(0, 4'b0101, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
    add(0, 4'b0101, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
    add(0, 4'b0101, 4'b0000, 4'b0100, 4'b1111, 4'b0000);
    add(0, 4'b0101, 4'b0100, 4'b0000, 4'b1011, 4'b0100);
    add(0, 4'b0101, 4'b0101, 4'b0000, 4'b1110, 4'b0001);

    foreach (vecs[i]) begin
      if (vecs[i].rst_before) reset_dut();
      step(vecs[i].iv, vecs[i].last, vecs[i].cgnt, vecs[i].ob, vecs[i].tgt, $sformatf("v%0d", i));
    end

    // Asynchronous reset between clock edges while VC1 streams.
    reset_dut();
    step(4'b0010, 4'b1111, 4'b0000, 4'b1101, 4'b0010, "pre-rst a");
    step(4'b0010, 4'b1111, 4'b0000, 4'b1101, 4'b0010, "pre-rst b");
    @(posedge clk);
    #1;
    chk("pre-rst link busy", 32'(rx.vc_target), 32'h2);
    #1;
    rst = 1'b1;
    #1;
    chk("async rst vc_target", 32'(rx.vc_target), 32'd0);
    chk("async rst packet", 32'(link_pkt()), 32'd0);
    for (int v = 0; v < VC_W; v++)
      chk($sformatf("async rst cnt%0d", v), 32'(dut.credit_cnt[v]), 32'(DEPTH - 1));
    @(negedge clk);
    i_v = '0;
    rst = 1'b0;
    step(4'b0011, 4'b1111, 4'b0000, 4'b1110, 4'b0001, "post-rst vc0 first");
    step(4'b0011, 4'b1111, 4'b0000, 4'b1101, 4'b0010, "post-rst vc1");
    step(4'b0010, 4'b1111, 4'b0000, 4'b1101, 4'b0010, "post-rst vc1 b");
    step(4'b0010, 4'b1111, 4'b0000, 4'b1101, 4'b0010, "post-rst vc1 c");
    step(4'b0010, 4'b1111, 4'b0000, 4'b1111, 4'b0000, "post-rst vc1 empty");

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vc_link_scheduler.md
# vc_link_scheduler

Transmit-side controller for one NoC link carrying `VC_W` virtual channels. It holds one credit counter per VC that mirrors free space in the matching receiver VC FIFO. Each cycle it round-robin arbitrates among VCs that have both a valid flit and a credit, then drives the winning flit onto the link through `noc_if`. It sits between the switch routing logic's per-VC DVR outputs and the link, and is the counterpart of the per-VC receive FIFO stage.

## Interface
- `VC_W`, `DEFAULT_VC_W`: number of virtual channels.
- `D_W`, `DEFAULT_D_W`: payload data width.
- `A_W`, `DEFAULT_A_W`: route address width.
- `DEPTH`, `DEFAULT_VC_FIFO_DEPTH`: receiver FIFO depth parameter. Usable credits are `DEPTH-1`.
- `LOCK_PKT`, 0: when 1, a VC keeps the link from its first flit until its `last` flit is sent.
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high.
- `i_v` input `[VC_W-1:0]`: per-VC flit valid from switch.
- `i_d` input `[VC_W-1:0][A_W+D_W:0]`: per-VC `{last, addr, data}`.
- `o_b` output `[VC_W-1:0]`: per-VC backpressure to switch; 1 means the flit is not taken this cycle.
- `to_rx` interface `noc_if.transmitter`:
  - drives `vc_target`, `packet.payload.last`, `packet.routeinfo.addr` and `packet.payload.data`;
  - samples `vc_credit_gnt`.

## Operation
- **Credit counters.**
  - Width is `$clog2(DEPTH)`; reset value is `DEPTH-1`.
  - Each cycle: `cnt <= cnt - send[v] + vc_credit_gnt[v]`.
  - Send and credit return on the same VC in the same cycle leave the count unchanged.
  - A return when `cnt == DEPTH-1` saturates the counter and fires an assertion.
- **Eligibility.** `elig[v] = i_v[v] & (cnt[v] != 0)`.
  - When `LOCK_PKT=1` and `locked`, only `lock_vc` is eligible.
- **Arbitration.**
  - Round-robin over `elig`, starting at `ptr+1` with modulo-`VC_W` wrap.
  - One-hot `gnt`; zero when no VC is eligible.
  - On a grant, `ptr <= granted index`; otherwise `ptr` holds.
- **Handshake.**
  - `o_b[v] = !gnt[v]`, combinational from `i_v`, counters, `ptr` and lock state.
  - A flit is consumed on a cycle with `i_v[v] & !o_b[v]`.
  - The upstream must hold `i_v` and `i_d` stable while backpressured.
- **Link drive (registered).**
  - `vc_target <= gnt`.
  - Packet fields `<= i_d[granted]` when any grant occurs.
  - Packet fields are zeroed when there is no grant, so `vc_target` is 0 on idle cycles.
- **Packet lock (`LOCK_PKT=1` only).** Lock is two-state, IDLE / LOCKED.
  - IDLE→LOCKED when a grant is made with `last=0`; `lock_vc` records the VC.
  - LOCKED→IDLE when `lock_vc` is granted with `last=1`.
  - While LOCKED and `lock_vc` lacks valid or credit, the link idles; other VCs stay backpressured.
- **Reset.** All of the following apply immediately on `rst`, regardless of in-flight traffic:
  - `vc_target=0` and packet fields 0;
  - counters at `DEPTH-1`;
  - `ptr=VC_W-1`, so VC0 wins first;
  - lock IDLE.

## Timing
- Credit return to credit usable: `vc_credit_gnt` at cycle N is usable for arbitration in cycle N+1.
- Flit accepted in cycle N appears on `to_rx` (`vc_target`, packet) in cycle N+1.
- Throughput: one flit per cycle on the link.
- A single VC with a round-trip of `DEPTH-1` or fewer cycles streams at full rate.
- With `cnt=0`, no grant is made on that VC even if a credit arrives in the same cycle.
- Maximum wait for an eligible VC with `LOCK_PKT=0` is `VC_W-1` grants.

## Structure
- `common_pkg` supplies `DEFAULT_*` constants.
- Add a `credit_cnt_w(depth)` function to `common_pkg`.
- One sub-module, `rr_arbiter`:
  - parameter `N`;
  - inputs `i_req[N]`, `i_ptr`;
  - outputs one-hot `o_gnt` and `o_idx`;
  - purely combinational.
- Credit counters, lock state machine and output registers live in `vc_link_scheduler`.
- Assertions are guarded by `SIMULATION`:
  - `vc_target` is at most one-hot;
  - no send at zero credit;
  - no credit return at full count;
  - `o_b` is known out of reset.

## Test plan
- **Credit exhaustion.** `VC_W=2`, `DEPTH=4`, VC0 valid continuously, no credit returns.
  - Exactly 3 flits sent in cycles 1–3, then `o_b[0]=1` permanently.
  - One `vc_credit_gnt[0]` pulse leads to exactly one more flit, 2 cycles later on the link.
- **Round-robin fairness.** 4 VCs all valid with ample credits.
  - Link `vc_target` sequence is 0001, 0010, 0100, 1000, 0001.
- **Simultaneous send and return.** VC1 at `cnt=1` sends while `vc_credit_gnt[1]=1`.
  - Count stays 1 and VC1 sends again the next cycle.
- **Packet lock.** `LOCK_PKT=1`; VC2 sends a 3-flit packet (`last=0,0,1`) while VC0 is valid.
  - VC0 is held off until VC2's `last` flit is sent, then VC0 is granted next.
- **Lock stall.** `LOCK_PKT=1`; VC2 runs out of credit mid-packet.
  - Link idles (`vc_target=0`) until a VC2 credit returns; VC0 stays backpressured.
- **Async reset mid-stream.** Assert `rst` between clock edges.
  - Outputs zero immediately and counters read `DEPTH-1`.
  - After release, VC0 is granted first.
